// File: rtl/sub_shift.sv
// AES SubBytes+ShiftRows (or inverse) on a 128-bit state. Four S-box lanes
// produce one output column per cycle; the S-boxes are computed in GF(2^8).

module sub_shift_sbox #(
  parameter bit INVERSE = 1'b0
) (
  input  logic [7:0] din,
  output logic [7:0] dout
);

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // x^254 == x^-1 for x != 0, and naturally maps 0 to 0
  function automatic logic [7:0] ginv(input logic [7:0] x);
    logic [7:0] t;
    t = x;
    for (int i = 0; i < 6; i++) t = gmul(gmul(t, t), x);
    return gmul(t, t);
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  function automatic logic [7:0] affine(input logic [7:0] x);
    return x ^ rotl(x, 1) ^ rotl(x, 2) ^ rotl(x, 3) ^ rotl(x, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_affine(input logic [7:0] x);
    return rotl(x, 1) ^ rotl(x, 3) ^ rotl(x, 6) ^ 8'h05;
  endfunction

  if (INVERSE) begin : g_inv
    assign dout = ginv(inv_affine(din));
  end else begin : g_fwd
    assign dout = affine(ginv(din));
  end

endmodule

module sub_shift #(
  parameter bit INVERSE = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  localparam int NUM_LANES = 4;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state, state_nxt;
  logic [1:0] cnt;
  // element 15-i holds byte b[i], so index ~{col,row} addresses row/col directly
  logic [15:0][7:0] in_q, out_q;
  logic [NUM_LANES-1:0][7:0] sb_in, sb_out;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)    state_nxt = RUN;
      RUN:     if (cnt == 2'd3) state_nxt = DONE;
      DONE:    if (out_ready)   state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_q  <= '0;
      out_q <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          in_q <= in_state;
          cnt  <= '0;
        end
        RUN: begin
          for (int r = 0; r < NUM_LANES; r++) out_q[~{cnt, 2'(r)}] <= sb_out[r];
          if (cnt != 2'd3) cnt <= cnt + 2'd1;
        end
        default: ;
      endcase
    end
  end

  // lane r serves row r; the shift is a rotation of the source column
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    localparam logic [1:0] ROW = 2'(g);
    logic [1:0] src_col;
    assign src_col  = INVERSE ? cnt - ROW : cnt + ROW;
    assign sb_in[g] = in_q[~{src_col, ROW}];
    sub_shift_sbox #(.INVERSE(INVERSE)) u_sbox (
      .din  (sb_in[g]),
      .dout (sb_out[g])
    );
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign out_state = out_q;

endmodule
